amba3ahblite_widget_p: RTL

- Parametrised AHB-Lite slave that bridges the system bus onto the internal register-access bus (addr, w_vld, r_vld, byte_enable, sw_wr_bus, sw_rd_bus).
- Generalised to 32- or 64-bit data and configurable address width.
- Adds slave-side wait-state handling from the register logic, two-cycle ERROR responses, size/alignment checking and an optional access timeout.
- Sits between the AHB-Lite interconnect and the generated register file.

---
 rtl/amba3ahblite_widget_p.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/amba3ahblite_widget_p.sv
// amba3ahblite_widget_p
//   AHB-Lite slave that turns accepted bus transfers into single requests on
//   the internal register-access bus and maps the register side's ready and
//   error returns back onto HREADYOUT/HRESP.
//
// Handshake (register side): w_vld/r_vld rise in the first data-phase cycle
//   and stay high, with addr/byte_enable/sw_wr_bus stable, until the cycle
//   in which the matching rdy is sampled high at a rising edge. That edge
//   completes the access; w_err/r_err are only looked at on that edge.
//
// Ports
//   HCLK, HRESETn           clock, asynchronous active-low reset
//   HSEL..HWDATA            AHB-Lite slave inputs (HBURST/HPROT/HMASTLOCK unused)
//   HREADYOUT, HRESP, HRDATA AHB-Lite slave outputs
//   addr, w_vld, r_vld, byte_enable, sw_wr_bus  register-bus request
//   sw_rd_bus, w_rdy, r_rdy, w_err, r_err        register-bus response
//   dbg_state_o             current FSM state
module amba3ahblite_widget_p #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic                    HSEL,
  input  logic [ADDR_WIDTH-1:0]   HADDR,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [1:0]              HTRANS,
  input  logic                    HMASTLOCK,
  input  logic                    HREADY,
  input  logic [DATA_WIDTH-1:0]   HWDATA,
  output logic                    HREADYOUT,
  output logic                    HRESP,
  output logic [DATA_WIDTH-1:0]   HRDATA,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    w_vld,
  output logic                    r_vld,
  output logic [DATA_WIDTH/8-1:0] byte_enable,
  output logic [DATA_WIDTH-1:0]   sw_wr_bus,
  input  logic [DATA_WIDTH-1:0]   sw_rd_bus,
  input  logic                    w_rdy,
  input  logic                    r_rdy,
  input  logic                    w_err,
  input  logic                    r_err,
  output logic [2:0]              dbg_state_o
);

  localparam int BE_W      = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BE_W);
  localparam int CNT_W     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_ACCESS = 3'd1;
  localparam logic [2:0] ST_DONE   = 3'd2;
  localparam logic [2:0] ST_ERR1   = 3'd3;
  localparam logic [2:0] ST_ERR2   = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  // A new address phase can only be taken while this slave is driving
  // HREADYOUT high, i.e. outside ACCESS and ERR1.
  logic slot_open;
  logic accept;
  assign slot_open = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR2);
  assign accept    = slot_open & HSEL & HREADY & HTRANS[1];

  // Size/alignment check and lane decode for the presented address phase.
  int unsigned     size_i;
  int unsigned     bytes_i;
  int unsigned     lane_i;
  int unsigned     align_mask;
  logic            size_bad;
  logic            misaligned;
  logic            check_bad;
  logic [BE_W-1:0] be_calc;

  always_comb begin
    size_i     = 32'(HSIZE);
    bytes_i    = 32'd1 << size_i;
    lane_i     = 32'(HADDR[LANE_BITS-1:0]);
    align_mask = bytes_i - 32'd1;
    size_bad   = size_i > 32'(LANE_BITS);
    misaligned = (lane_i & align_mask) != 32'd0;
    check_bad  = size_bad | misaligned;
    be_calc    = '0;
    for (int i = 0; i < BE_W; i++) begin
      if ((32'(i) >= lane_i) && (32'(i) < lane_i + bytes_i)) be_calc[i] = 1'b1;
    end
  end

  // Completion signals of the access in flight; err only matters with rdy.
  logic acc_rdy;
  logic acc_err;
  logic timeout_hit;
  assign acc_rdy     = write_q ? w_rdy : r_rdy;
  assign acc_err     = write_q ? w_err : r_err;
  // cnt_q counts ACCESS cycles already spent; this cycle is number cnt_q+1.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) &&
                       ((32'(cnt_q) + 32'd1) >= 32'(TIMEOUT_CYCLES));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR2: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR;
          write_d = HWRITE;
          if (check_bad) begin
            state_d = ST_ERR1;
            be_d    = '0;
          end else begin
            state_d = ST_ACCESS;
            be_d    = be_calc;
          end
        end
      end
      ST_ACCESS: begin
        // rdy takes priority over a timeout in the same cycle.
        if (acc_rdy) begin
          if (acc_err) begin
            state_d = ST_ERR1;
          end else begin
            state_d = ST_DONE;
            if (!write_q) rdata_d = sw_rd_bus;
          end
        end else if (timeout_hit) begin
          state_d = ST_ERR1;
        end else begin
          state_d = ST_ACCESS;
          cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        end
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      be_q    <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign HREADYOUT   = !((state_q == ST_ACCESS) || (state_q == ST_ERR1));
  assign HRESP       = (state_q == ST_ERR1) || (state_q == ST_ERR2);
  assign HRDATA      = rdata_q;
  assign addr        = addr_q;
  assign w_vld       = (state_q == ST_ACCESS) & write_q;
  assign r_vld       = (state_q == ST_ACCESS) & ~write_q;
  assign byte_enable = be_q;
  // The master holds HWDATA while HREADYOUT is low, so it is stable in ACCESS.
  assign sw_wr_bus   = HWDATA;
  assign dbg_state_o = state_q;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

endmodule
